// File: rtl/xor2_arc_seq.sv
// Self-test sequencer for a single xor2 cell: walks A1/A2 through a Gray-code
// loop hitting all four input arcs, samples Z after a settle window and scores it.
module xor2_arc_seq #(
    parameter int SETTLE = 2,
    parameter int CNT_W  = 8
) (
    input  logic             CLK,
    input  logic             RST,
    inout  wire              VDD,
    inout  wire              VSS,
    input  logic             start,
    input  logic [7:0]       loops,
    input  logic             Z,
    output logic             A1,
    output logic             A2,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic [1:0]       first_fail_arc,
    output logic [1:0]       arc_idx
);

    // state  | meaning
    // S_IDLE | waiting for start; outputs hold the last run's result
    // S_RUN  | one settle window per arc, sample Z on the window's last edge
    typedef enum logic {S_IDLE, S_RUN} state_t;

    localparam logic [3:0] SETTLE_L = 4'(SETTLE);

    state_t           r_state;
    logic [3:0]       r_settle;
    logic [7:0]       r_loop_cnt;
    logic             r_a1;
    logic             r_a2;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [CNT_W-1:0] r_err_cnt;
    logic [1:0]       r_first_fail_arc;
    logic [1:0]       r_arc_idx;

    logic w_mismatch;
    logic w_last_arc;
    logic w_unused_pwr;

    // Supply pins only exist so the wrapper netlist can hook them up.
    assign w_unused_pwr = VDD ^ VSS;

    assign w_mismatch = (Z != (r_a1 ^ r_a2));
    assign w_last_arc = (r_arc_idx == 2'd3) && (r_loop_cnt == 8'd1);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state          <= S_IDLE;
            r_settle         <= '0;
            r_loop_cnt       <= '0;
            r_a1             <= 1'b0;
            r_a2             <= 1'b0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_pass           <= 1'b0;
            r_err_cnt        <= '0;
            r_first_fail_arc <= '0;
            r_arc_idx        <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (loops != 8'd0) begin
                            r_state          <= S_RUN;
                            r_busy           <= 1'b1;
                            r_err_cnt        <= '0;
                            r_first_fail_arc <= '0;
                            r_loop_cnt       <= loops;
                            r_a1             <= 1'b1;
                            r_arc_idx        <= 2'd0;
                            r_settle         <= SETTLE_L;
                        end else begin
                            r_done    <= 1'b1;
                            r_pass    <= 1'b1;
                            r_err_cnt <= '0;
                        end
                    end
                end
                S_RUN: begin
                    if (r_settle == 4'd1) begin
                        // err_cnt never returns to zero within a run, so it doubles as "seen a mismatch"
                        if (w_mismatch) begin
                            if (r_err_cnt != '1)
                                r_err_cnt <= r_err_cnt + CNT_W'(1);
                            if (r_err_cnt == '0)
                                r_first_fail_arc <= r_arc_idx;
                        end
                        if (w_last_arc) begin
                            r_state  <= S_IDLE;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_pass   <= (r_err_cnt == '0) && !w_mismatch;
                            r_settle <= '0;
                            r_a2     <= 1'b0;
                        end else begin
                            r_arc_idx <= r_arc_idx + 2'd1;
                            r_settle  <= SETTLE_L;
                            case (r_arc_idx)
                                2'd0: r_a2 <= 1'b1;
                                2'd1: r_a1 <= 1'b0;
                                2'd2: r_a2 <= 1'b0;
                                default: begin
                                    r_a1       <= 1'b1;
                                    r_loop_cnt <= r_loop_cnt - 8'd1;
                                end
                            endcase
                        end
                    end else begin
                        r_settle <= r_settle - 4'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign A1             = r_a1;
    assign A2             = r_a2;
    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign err_cnt        = r_err_cnt;
    assign first_fail_arc = r_first_fail_arc;
    assign arc_idx        = r_arc_idx;

endmodule
